// File: rtl/trng_sampler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trng_sampler: synchronizer, von Neumann debias and WIDTH-bit packer on a
// valid/ready stream. TRNG_SAMPLER_RCT_EN adds the repetition-count test.
// Revision: 1.0
// ---------------------------------------------------------------------------
module trng_sampler #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RCT_LIMIT   = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             raw_bit,
  input  logic             clear,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             overflow,
  output logic             fault
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [0:0] ST_FIRST  = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [0:0]             state_q, state_d;
  logic                   a_q, a_d;
  logic [WIDTH-1:0]       word_q, word_d, word_full;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   emit, complete, load, ovf_set;
  logic [WIDTH-1:0]       data_q;
  logic                   valid_q, valid_d, overflow_q;
  logic                   fault_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_bit};
  end
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_FIRST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FIRST;
    if (enable) begin
      case (state_q)
        ST_FIRST:  state_d = ST_SECOND;
        default:   state_d = ST_FIRST;
      endcase
    end
  end

  // Only unequal pairs yield a bit; 00 and 11 are thrown away.
  always_comb begin
    emit = 1'b0;
    if (enable && (state_q == ST_SECOND) && (a_q != s)) emit = 1'b1;
  end

  assign word_full = {word_q[WIDTH-2:0], a_q};
  assign complete  = emit && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    a_d    = a_q;
    word_d = word_q;
    cnt_d  = cnt_q;
    if (!enable) begin
      word_d = '0;
      cnt_d  = '0;
    end else begin
      if (state_q == ST_FIRST) a_d = s;
      if (emit) begin
        word_d = word_full;
        cnt_d  = complete ? '0 : cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      a_q    <= 1'b0;
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  // A faulted source never delivers words, and those drops are not overflows.
  assign load    = complete && !fault_q && (!valid_q || ready);
  assign ovf_set = complete && !fault_q && valid_q && !ready;

  always_comb begin
    valid_d = valid_q;
    if (load)                 valid_d = 1'b1;
    else if (valid_q && ready) valid_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (load) data_q <= word_full;
      valid_q    <= valid_d;
      overflow_q <= ovf_set | (overflow_q & ~clear);
    end
  end

`ifdef TRNG_SAMPLER_RCT_EN
  localparam int RW = $clog2(RCT_LIMIT + 1);
  logic [RW-1:0] run_q, run_d;
  logic          s_prev_q, fault_set;

  // The fault fires on the cycle the run first reaches the limit; clear
  // restarts the run but cannot mask a simultaneous set event.
  always_comb begin
    run_d     = run_q;
    fault_set = 1'b0;
    if (enable) begin
      if (s == s_prev_q) begin
        if (run_q == RW'(RCT_LIMIT - 1)) fault_set = 1'b1;
        if (run_q != {RW{1'b1}})         run_d = run_q + 1'b1;
      end else begin
        run_d = RW'(1);
      end
    end
    if (clear) run_d = RW'(1);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      run_q    <= '0;
      s_prev_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      run_q    <= run_d;
      s_prev_q <= s;
      fault_q  <= fault_set | (fault_q & ~clear);
    end
  end
`else
  logic rct_unused;
  assign rct_unused = (RCT_LIMIT != 0);
  assign fault_q    = 1'b0;
`endif

  assign data_out = data_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign fault    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_trng_sampler.sv
`default_nettype none
// Bench for trng_sampler: directed test-plan sequences plus random traffic,
// all compared against a queue-based model of sampling, debiasing and packing.
module tb_trng_sampler;
  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int LIMIT = 64;

  logic             CLK = 1'b0, RESET = 1'b0, enable = 1'b0, raw_bit = 1'b0;
  logic             clear = 1'b0, ready = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             valid, overflow, fault;

  trng_sampler #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .RCT_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .raw_bit(raw_bit), .clear(clear),
    .data_out(data_out), .valid(valid), .ready(ready), .overflow(overflow), .fault(fault)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  bit               hist[$];
  bit               samples[$];
  bit               bits[$];
  logic [WIDTH-1:0] m_data;
  bit               m_valid, m_ovf, m_fault, prev;
  int               rc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    samples.delete();
    bits.delete();
    m_data = '0; m_valid = 0; m_ovf = 0; m_fault = 0; prev = 0; rc = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},     data_out, m_data);
    chk({tag, ".valid"},    valid,    m_valid);
    chk({tag, ".overflow"}, overflow, m_ovf);
    chk({tag, ".fault"},    fault,    m_fault);
  endtask

  // One clock: drive on negedge, advance the model at posedge, check after.
  task automatic cyc(input bit en, input bit raw, input bit rdy, input bit clr);
    bit s, done, fset, ovf;
    logic [WIDTH-1:0] w;
    @(negedge CLK);
    enable = en; raw_bit = raw; ready = rdy; clear = clr;
    @(posedge CLK);
    s = hist.pop_front();
    hist.push_back(raw);
    done = 0; w = '0;
    if (!en) begin
      samples.delete();
      bits.delete();
    end else begin
      samples.push_back(s);
      if (samples.size() == 2) begin
        if (samples[0] != samples[1]) bits.push_back(samples[0]);
        samples.delete();
      end
      if (bits.size() == WIDTH) begin
        foreach (bits[i]) w = {w[WIDTH-2:0], bits[i]};
        bits.delete();
        done = 1;
      end
    end
    fset = 0;
`ifdef TRNG_SAMPLER_RCT_EN
    if (en) begin
      if (s == prev) begin
        if (rc == LIMIT - 1) fset = 1;
        if (rc < LIMIT) rc++;
      end else rc = 1;
    end
    if (clr) rc = 1;
`endif
    prev = s;
    ovf = 0;
    if (done && !m_fault && (!m_valid || rdy)) begin
      m_data = w; m_valid = 1;
    end else begin
      if (done && !m_fault) ovf = 1;
      if (m_valid && rdy) m_valid = 0;
    end
    m_ovf   = ovf  | (m_ovf & !clr);
    m_fault = fset | (m_fault & !clr);
    #1;
    check_all("cyc");
  endtask

  // Feed n synchronized samples (MSB first) as one fresh enabled run.
  task automatic feed(input logic [63:0] pat, input int n, input bit rdy, input int pulse);
    bit r;
    for (int j = 0; j < n + SYNC; j++) begin
      r = 1'b0;
      if (j < n) r = pat[n-1-j];
      cyc(j >= SYNC, r, rdy || (j == pulse), 1'b0);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rdy, 1'b0);
  endtask

  localparam logic [63:0] P_B2      = 64'h9A59;
  localparam logic [63:0] P_B2_4D   = 64'h9A5965A6;
  localparam logic [63:0] P_DISCARD = 64'h27A179;
  localparam logic [63:0] P_PART    = 64'h269;

  initial begin
    model_reset();
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      raw_bit = ~raw_bit;
    end
    @(posedge CLK);
    #1;
    check_all("reset");
    RESET = 1'b1;

    feed(P_B2, 16, 1'b1, -1);
    chk("b2.data", data_out, 32'hB2);
    chk("b2.valid", valid, 1);
    idle(3, 1'b1);
    chk("b2.valid_drop", valid, 0);

    feed(P_DISCARD, 22, 1'b1, -1);
    chk("discard.data", data_out, 32'hB2);
    chk("discard.valid", valid, 1);
    idle(3, 1'b1);

    feed(P_B2_4D, 32, 1'b0, -1);
    chk("bp.data", data_out, 32'hB2);
    chk("bp.overflow", overflow, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp.accept_valid", valid, 0);
    chk("bp.hold_data", data_out, 32'hB2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp.clear", overflow, 0);

    feed(P_B2_4D, 32, 1'b0, SYNC + 31);
    chk("simul.data", data_out, 32'h4D);
    chk("simul.valid", valid, 1);
    chk("simul.overflow", overflow, 0);
    idle(2, 1'b1);

    feed(P_PART, 10, 1'b1, -1);
    idle(2, 1'b1);
    feed(P_B2, 16, 1'b1, -1);
    chk("endrop.data", data_out, 32'hB2);
    idle(2, 1'b1);

    feed(P_B2, 16, 1'b0, -1);
    #2 RESET = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    RESET = 1'b1;

    for (int i = 0; i < 400; i++)
      cyc(($urandom % 8) != 0, $urandom % 2, $urandom % 2, ($urandom % 16) == 0);

    for (int i = 0; i < LIMIT + 16; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
`ifdef TRNG_SAMPLER_RCT_EN
    chk("rct.fault", fault, 1);
    chk("rct.no_valid", valid, 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, i[0], 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rct.cleared", fault, 0);
    idle(2, 1'b1);
    feed(P_B2, 16, 1'b1, -1);
    chk("rct.resume", data_out, 32'hB2);
`else
    chk("norct.fault", fault, 0);
`endif
    idle(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
